sdram_arbit: RTL and testbench

SDRAM_ARBIT -- requirements
Module: sdram_arbit

---
 rtl/sdram_arbit_pkg.sv | 24 ++
 rtl/sdram_ref_timer.sv | 51 +++++
 rtl/sdram_arbit.sv | 129 ++++++++++++
 tb/tb_sdram_arbit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arbit_pkg.sv
// Shared definitions for the SDRAM command arbiter: command encodings
// {cs_n,ras_n,cas_n,we_n}, arbiter states and the default refresh interval.
package sdram_arbit_pkg;

    // 15 us at 50 MHz
    localparam int unsigned REF_PERIOD_DEF = 750;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_MSET = 4'b0000;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_RD   = 4'b0101;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_ARBIT,
        ST_AREF,
        ST_WRITE,
        ST_READ
    } state_t;

endpackage

// File: rtl/sdram_ref_timer.sv
// Auto-refresh interval timer. Raises ref_req every REF_PERIOD cycles once
// initialisation is done, drops it when the arbiter grants the refresh, and
// latches ref_miss if an interval expires while the previous one is still
// waiting for its grant.
module sdram_ref_timer
    import sdram_arbit_pkg::*;
#(
    parameter int unsigned REF_PERIOD = REF_PERIOD_DEF
) (
    input  logic sclk,
    input  logic s_rst_n,
    input  logic flag_init_end,
    input  logic ref_en,
    output logic ref_req,
    output logic ref_miss
);

    localparam int unsigned   CW   = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(REF_PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d;
    logic          miss_q, miss_d;
    logic          wrap;

    // A wrap coinciding with the grant leaves the request set for the new
    // interval; only a wrap against an ungranted request counts as a miss.
    always_comb begin
        wrap   = flag_init_end && (cnt_q == LAST);
        cnt_d  = (!flag_init_end || wrap) ? '0 : cnt_q + 1'b1;
        req_d  = wrap | (req_q & ~ref_en);
        miss_d = miss_q | (wrap & req_q & ~ref_en);
    end

    // Interval counter and request/miss flags
    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            cnt_q  <= '0;
            req_q  <= 1'b0;
            miss_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            req_q  <= req_d;
            miss_q <= miss_d;
        end
    end

    assign ref_req  = req_q;
    assign ref_miss = miss_q;

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM command bus arbiter. After the init sequencer finishes, grants the
// bus to the refresh, write or read engine (refresh first, then write, then
// read) and muxes the owning engine's command, address and bank onto the
// SDRAM pins until that engine signals completion.
module sdram_arbit
    import sdram_arbit_pkg::*;
#(
    parameter int unsigned REF_PERIOD = REF_PERIOD_DEF,
    parameter logic [3:0]  NOP        = CMD_NOP
) (
    input  logic        sclk,
    input  logic        s_rst_n,
    input  logic        flag_init_end,
    input  logic [3:0]  init_cmd,
    input  logic [11:0] init_addr,
    input  logic [3:0]  ref_cmd,
    input  logic [3:0]  wr_cmd,
    input  logic [3:0]  rd_cmd,
    input  logic [11:0] ref_addr,
    input  logic [11:0] wr_addr,
    input  logic [11:0] rd_addr,
    input  logic [1:0]  wr_ba,
    input  logic [1:0]  rd_ba,
    input  logic        wr_req,
    input  logic        rd_req,
    input  logic        ref_end,
    input  logic        wr_end,
    input  logic        rd_end,
    output logic        ref_en,
    output logic        wr_en,
    output logic        rd_en,
    output logic        ref_req,
    output logic        ref_miss,
    output logic [3:0]  sdram_cmd,
    output logic [11:0] sdram_addr,
    output logic [1:0]  sdram_ba,
    output logic        sdram_cke
);

    state_t state_q;
    logic   ref_en_q, wr_en_q, rd_en_q;

    sdram_ref_timer #(
        .REF_PERIOD (REF_PERIOD)
    ) u_ref_timer (
        .sclk          (sclk),
        .s_rst_n       (s_rst_n),
        .flag_init_end (flag_init_end),
        .ref_en        (ref_en_q),
        .ref_req       (ref_req),
        .ref_miss      (ref_miss)
    );

    // Arbiter FSM: grant pulses are registered with the state change so each
    // is high only for the first cycle spent in the granted state.
    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            state_q  <= ST_INIT;
            ref_en_q <= 1'b0;
            wr_en_q  <= 1'b0;
            rd_en_q  <= 1'b0;
        end else begin
            ref_en_q <= 1'b0;
            wr_en_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    if (flag_init_end) state_q <= ST_ARBIT;
                end
                ST_ARBIT: begin
                    if (ref_req) begin
                        state_q  <= ST_AREF;
                        ref_en_q <= 1'b1;
                    end else if (wr_req) begin
                        state_q <= ST_WRITE;
                        wr_en_q <= 1'b1;
                    end else if (rd_req) begin
                        state_q <= ST_READ;
                        rd_en_q <= 1'b1;
                    end
                end
                ST_AREF: begin
                    if (ref_end) state_q <= ST_ARBIT;
                end
                ST_WRITE: begin
                    if (wr_end) state_q <= ST_ARBIT;
                end
                ST_READ: begin
                    if (rd_end) state_q <= ST_ARBIT;
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    // Command bus mux selected by the current owner
    always_comb begin
        sdram_cmd  = NOP;
        sdram_addr = '0;
        sdram_ba   = '0;
        case (state_q)
            ST_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                sdram_cmd  = ref_cmd;
                sdram_addr = ref_addr;
            end
            ST_WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_addr = wr_addr;
                sdram_ba   = wr_ba;
            end
            ST_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
                sdram_ba   = rd_ba;
            end
            default: ;
        endcase
    end

    assign ref_en    = ref_en_q;
    assign wr_en     = wr_en_q;
    assign rd_en     = rd_en_q;
    assign sdram_cke = 1'b1;

endmodule

// File: tb/tb_sdram_arbit.sv
// Self-checking bench for sdram_arbit with a short refresh interval.
// A behavioural model tracks the bus owner and refresh bookkeeping
// (interval expiry from an enabled-cycle count) and predicts every output.
module tb_sdram_arbit;

    localparam int P = 20;

    localparam int M_INIT = 0;
    localparam int M_IDLE = 1;
    localparam int M_REF  = 2;
    localparam int M_WR   = 3;
    localparam int M_RD   = 4;

    logic        sclk = 1'b0;
    logic        s_rst_n;
    logic        flag_init_end;
    logic [3:0]  init_cmd, ref_cmd, wr_cmd, rd_cmd;
    logic [11:0] init_addr, ref_addr, wr_addr, rd_addr;
    logic [1:0]  wr_ba, rd_ba;
    logic        wr_req, rd_req;
    logic        ref_end, wr_end, rd_end;
    logic        ref_en, wr_en, rd_en;
    logic        ref_req, ref_miss;
    logic [3:0]  sdram_cmd;
    logic [11:0] sdram_addr;
    logic [1:0]  sdram_ba;
    logic        sdram_cke;

    always #5 sclk = ~sclk;

    sdram_arbit #(
        .REF_PERIOD (P),
        .NOP        (4'b0111)
    ) dut (
        .sclk          (sclk),
        .s_rst_n       (s_rst_n),
        .flag_init_end (flag_init_end),
        .init_cmd      (init_cmd),
        .init_addr     (init_addr),
        .ref_cmd       (ref_cmd),
        .wr_cmd        (wr_cmd),
        .rd_cmd        (rd_cmd),
        .ref_addr      (ref_addr),
        .wr_addr       (wr_addr),
        .rd_addr       (rd_addr),
        .wr_ba         (wr_ba),
        .rd_ba         (rd_ba),
        .wr_req        (wr_req),
        .rd_req        (rd_req),
        .ref_end       (ref_end),
        .wr_end        (wr_end),
        .rd_end        (rd_end),
        .ref_en        (ref_en),
        .wr_en         (wr_en),
        .rd_en         (rd_en),
        .ref_req       (ref_req),
        .ref_miss      (ref_miss),
        .sdram_cmd     (sdram_cmd),
        .sdram_addr    (sdram_addr),
        .sdram_ba      (sdram_ba),
        .sdram_cke     (sdram_cke)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int m_mode  = M_INIT;
    int m_on    = 0;
    bit m_req   = 1'b0;
    bit m_miss  = 1'b0;
    bit m_ref_g = 1'b0;
    bit m_wr_g  = 1'b0;
    bit m_rd_g  = 1'b0;
    bit armed   = 1'b0;

    // Advance the model by one rising edge using the inputs present at it.
    task automatic model_step();
        bit expired;
        bit pend_before;
        bit granted_now;
        expired     = 1'b0;
        pend_before = m_req;
        granted_now = m_ref_g;
        if (!s_rst_n) begin
            m_mode  = M_INIT;
            m_on    = 0;
            m_req   = 1'b0;
            m_miss  = 1'b0;
            m_ref_g = 1'b0;
            m_wr_g  = 1'b0;
            m_rd_g  = 1'b0;
            armed   = 1'b1;
            return;
        end
        if (flag_init_end) begin
            m_on++;
            expired = (m_on % P) == 0;
        end else begin
            m_on = 0;
        end
        if (expired) begin
            if (pend_before && !granted_now) m_miss = 1'b1;
            m_req = 1'b1;
        end else if (granted_now) begin
            m_req = 1'b0;
        end
        m_ref_g = 1'b0;
        m_wr_g  = 1'b0;
        m_rd_g  = 1'b0;
        case (m_mode)
            M_INIT: if (flag_init_end) m_mode = M_IDLE;
            M_IDLE: begin
                if (pend_before)  begin m_mode = M_REF; m_ref_g = 1'b1; end
                else if (wr_req)  begin m_mode = M_WR;  m_wr_g  = 1'b1; end
                else if (rd_req)  begin m_mode = M_RD;  m_rd_g  = 1'b1; end
            end
            M_REF: if (ref_end) m_mode = M_IDLE;
            M_WR:  if (wr_end)  m_mode = M_IDLE;
            default: if (rd_end) m_mode = M_IDLE;
        endcase
    endtask

    function automatic logic [17:0] exp_bus();
        case (m_mode)
            M_INIT:  return {init_cmd, init_addr, 2'b00};
            M_IDLE:  return {4'b0111, 12'h000, 2'b00};
            M_REF:   return {ref_cmd, ref_addr, 2'b00};
            M_WR:    return {wr_cmd, wr_addr, wr_ba};
            default: return {rd_cmd, rd_addr, rd_ba};
        endcase
    endfunction

    // One clock: model steps on the edge, outputs are compared mid-cycle.
    task automatic cycle();
        @(posedge sclk);
        model_step();
        @(negedge sclk);
        if (armed) begin
            check("bus", 32'({sdram_cmd, sdram_addr, sdram_ba}), 32'(exp_bus()));
            check("flags", 32'({ref_en, wr_en, rd_en, ref_req, ref_miss, sdram_cke}),
                  32'({m_ref_g, m_wr_g, m_rd_g, m_req, m_miss, 1'b1}));
        end
    endtask

    task automatic rand_bus();
        init_cmd  = 4'($urandom);
        ref_cmd   = 4'($urandom);
        wr_cmd    = 4'($urandom);
        rd_cmd    = 4'($urandom);
        init_addr = 12'($urandom);
        ref_addr  = 12'($urandom);
        wr_addr   = 12'($urandom);
        rd_addr   = 12'($urandom);
        wr_ba     = 2'($urandom);
        rd_ba     = 2'($urandom);
    endtask

    initial begin
        bit pend_ref;
        s_rst_n = 1'b0; flag_init_end = 1'b0;
        wr_req = 1'b0; rd_req = 1'b0;
        ref_end = 1'b0; wr_end = 1'b0; rd_end = 1'b0;
        rand_bus();
        @(negedge sclk);
        cycle();
        cycle();
        check("rst_flags", 32'({ref_en, wr_en, rd_en, ref_req, ref_miss, sdram_cke}), 32'h01);
        check("rst_cmd", 32'(sdram_cmd), 32'(init_cmd));

        // Init held off: bus follows the init sequencer, no refresh requested
        s_rst_n = 1'b1;
        repeat (50) begin
            rand_bus();
            wr_req = 1'($urandom);
            cycle();
            check("init_noref", 32'(ref_req), 32'd0);
        end

        // First write after init
        flag_init_end = 1'b1; wr_req = 1'b1; rd_req = 1'b0;
        rand_bus(); cycle();
        check("wr_en_early", 32'(wr_en), 32'd0);
        rand_bus(); cycle();
        check("wr_en_lat", 32'(wr_en), 32'd1);
        rand_bus(); cycle();
        check("wr_en_once", 32'(wr_en), 32'd0);
        wr_req = 1'b0;
        repeat (5) begin
            rand_bus(); cycle();
            check("wr_cmd_follow", 32'(sdram_cmd), 32'(wr_cmd));
        end
        wr_end = 1'b1; rand_bus(); cycle();
        wr_end = 1'b0;
        check("after_wr_nop", 32'({sdram_cmd, sdram_addr}), 32'({4'b0111, 12'h000}));

        // Both engines busy: a write must follow every refresh before a read
        wr_req = 1'b1; rd_req = 1'b1; pend_ref = 1'b0;
        repeat (200) begin
            rand_bus();
            ref_end = ($urandom_range(0, 2) == 0);
            wr_end  = ($urandom_range(0, 2) == 0);
            rd_end  = ($urandom_range(0, 2) == 0);
            cycle();
            if (ref_en) pend_ref = 1'b1;
            else if (pend_ref && (wr_en || rd_en)) begin
                check("wr_after_ref", 32'({wr_en, rd_en}), 32'd2);
                pend_ref = 1'b0;
            end
        end

        // Random traffic with stray completion pulses
        repeat (300) begin
            rand_bus();
            wr_req  = ($urandom_range(0, 3) != 0);
            rd_req  = ($urandom_range(0, 3) != 0);
            ref_end = ($urandom_range(0, 2) == 0);
            wr_end  = ($urandom_range(0, 2) == 0);
            rd_end  = ($urandom_range(0, 2) == 0);
            cycle();
        end

        // Refresh completion withheld long enough for a second expiry
        wr_req = 1'b0; rd_req = 1'b0;
        ref_end = 1'b1; wr_end = 1'b1; rd_end = 1'b1;
        rand_bus(); cycle();
        ref_end = 1'b0; wr_end = 1'b0; rd_end = 1'b0;
        repeat (70) begin rand_bus(); cycle(); end
        check("miss_set", 32'(ref_miss), 32'd1);
        repeat (40) begin
            rand_bus();
            ref_end = 1'($urandom);
            cycle();
            check("miss_sticky", 32'(ref_miss), 32'd1);
        end

        // Expiry on the same edge as the refresh grant
        s_rst_n = 1'b0; flag_init_end = 1'b0; ref_end = 1'b0;
        rand_bus(); cycle();
        s_rst_n = 1'b1; flag_init_end = 1'b1; wr_req = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            if (i >= 3) wr_req = 1'b0;
            wr_end = (i == 38);
            rand_bus();
            cycle();
            if (i == 39) check("coinc_grant", 32'(ref_en), 32'd1);
            if (i == 40) check("coinc_state", 32'({ref_req, ref_miss}), 32'd2);
        end
        wr_end = 1'b0;

        // Reset in the middle of a write burst
        s_rst_n = 1'b0; rand_bus(); cycle();
        s_rst_n = 1'b1; wr_req = 1'b1;
        repeat (2) begin rand_bus(); cycle(); end
        check("mid_wr_grant", 32'(wr_en), 32'd1);
        wr_req = 1'b0;
        repeat (3) begin rand_bus(); cycle(); end
        s_rst_n = 1'b0; rand_bus(); cycle();
        check("midrst_en", 32'({ref_en, wr_en, rd_en, ref_req}), 32'd0);
        check("midrst_cmd", 32'(sdram_cmd), 32'(init_cmd));
        s_rst_n = 1'b1;
        repeat (100) begin
            rand_bus();
            wr_req  = 1'($urandom);
            rd_req  = 1'($urandom);
            ref_end = ($urandom_range(0, 2) == 0);
            wr_end  = ($urandom_range(0, 2) == 0);
            rd_end  = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
